// File: rtl/rgb_matrix_shift_driver.sv
// Serial driver for the 8x8 RGB matrix shift-register chain (74HC595 style).
// Each frame snapshots the per-car one-hot floor vectors, shifts a 24-bit
// {R,G,B} frame MSB-first, latches it, then holds it while PWM-dimming via OE.
module rgb_matrix_shift_driver #(
    parameter int NUM_CARS   = 2,
    parameter int FLOORS     = 4,
    parameter int CLK_DIV    = 4,
    parameter int HOLD_TICKS = 64,
    parameter int BRIGHT     = 12,
    parameter int ROW_W      = 2,
    parameter int ROW_SEL    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CARS*FLOORS-1:0]   car_floor,
    output logic [ROW_W-1:0]             row,
    output logic                         SH_CP,
    output logic                         ST_CP,
    output logic                         OE,
    output logic                         MR,
    output logic                         data,
    output logic                         frame_done,
    output logic [NUM_CARS-1:0]          fault
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    // Parameter sanity: every car field must fit inside one plane byte.
    if (NUM_CARS * FLOORS > 8) begin : g_bad_width
        $error("rgb_matrix_shift_driver: NUM_CARS*FLOORS must be <= 8");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("rgb_matrix_shift_driver: CLK_DIV must be >= 1");
    end
    if (HOLD_TICKS < 16) begin : g_bad_hold
        $error("rgb_matrix_shift_driver: HOLD_TICKS must be >= 16");
    end
    if (BRIGHT < 0 || BRIGHT > 16) begin : g_bad_bright
        $error("rgb_matrix_shift_driver: BRIGHT must be in 0..16");
    end

    typedef enum logic [2:0] {
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        HOLD
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [23:0]         frame;
    logic [23:0]         frame_next;
    logic [NUM_CARS-1:0] bad_now;
    logic [4:0]          bit_idx;
    logic [HOLD_W-1:0]   hold_cnt;

    // OE level for a given hold tick: on for the first BRIGHT ticks of every 16.
    function automatic logic oe_level(input logic [3:0] h);
        return ({1'b0, h} < 5'(BRIGHT)) ? 1'b0 : 1'b1;
    endfunction

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Free-running divider producing the shift tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Build the frame from live inputs; only consumed at the LOAD tick.
    always_comb begin
        frame_next = '0;
        bad_now    = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if ($countones(car_floor[k*FLOORS +: FLOORS]) == 1) begin
                frame_next[16 - 8*(k % 3) + k*FLOORS +: FLOORS] =
                    frame_next[16 - 8*(k % 3) + k*FLOORS +: FLOORS] | car_floor[k*FLOORS +: FLOORS];
            end else begin
                bad_now[k] = 1'b1;
            end
        end
    end

    // Chain master reset release and constant row select after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MR  <= 1'b0;
            row <= '0;
        end else begin
            MR  <= 1'b1;
            row <= ROW_W'(ROW_SEL);
        end
    end

    // Frame sequencer: LOAD -> 24 x (SHIFT_LO, SHIFT_HI) -> LATCH -> HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            frame      <= '0;
            bit_idx    <= 5'd23;
            hold_cnt   <= '0;
            SH_CP      <= 1'b0;
            ST_CP      <= 1'b0;
            data       <= 1'b0;
            OE         <= 1'b1;
            frame_done <= 1'b0;
            fault      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    LOAD: begin
                        frame   <= frame_next;
                        fault   <= fault | bad_now;
                        bit_idx <= 5'd23;
                        data    <= frame_next[23];
                        SH_CP   <= 1'b0;
                        OE      <= 1'b1;
                        state   <= SHIFT_LO;
                    end
                    SHIFT_LO: begin
                        SH_CP <= 1'b1;
                        state <= SHIFT_HI;
                    end
                    SHIFT_HI: begin
                        SH_CP <= 1'b0;
                        if (bit_idx == 5'd0) begin
                            ST_CP <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                            data    <= frame[bit_idx - 5'd1];
                            state   <= SHIFT_LO;
                        end
                    end
                    LATCH: begin
                        ST_CP      <= 1'b0;
                        data       <= 1'b0;
                        frame_done <= 1'b1;
                        hold_cnt   <= '0;
                        OE         <= oe_level(4'd0);
                        state      <= HOLD;
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            OE    <= 1'b1;
                            state <= LOAD;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                            OE       <= oe_level(4'(hold_cnt + 1'b1));
                        end
                    end
                    default: begin
                        OE    <= 1'b1;
                        state <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_matrix_shift_driver.sv
// Bench for rgb_matrix_shift_driver: four parameter sets share clock, reset
// and stimulus; a tick/position model predicts every output each cycle.
module tb_rgb_matrix_shift_driver;

    localparam int NCFG = 4;
    localparam int P_NC[NCFG]   = '{2, 2, 2, 3};
    localparam int P_FL[NCFG]   = '{4, 4, 4, 2};
    localparam int P_CD[NCFG]   = '{1, 2, 1, 3};
    localparam int P_HOLD[NCFG] = '{16, 32, 16, 20};
    localparam int P_BR[NCFG]   = '{12, 4, 0, 16};
    // Hand-derived per-frame figures: period clks, OE-low clks, first-to-last SH_CP rise span.
    localparam int EXP_PERIOD[NCFG] = '{66, 164, 66, 210};
    localparam int EXP_OE[NCFG]     = '{12, 16, 0, 60};
    localparam int EXP_SPAN[NCFG]   = '{46, 92, 46, 138};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cf_all;

    // {SH_CP, ST_CP, data, OE, MR, row[1:0], frame_done, fault[2:0]}
    logic [10:0] act_a  [NCFG];
    logic [10:0] exp_a  [NCFG];
    logic [10:0] care_a [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int NC   = P_NC[g];
        localparam int FL   = P_FL[g];
        localparam int CD   = P_CD[g];
        localparam int HOLD = P_HOLD[g];
        localparam int BR   = P_BR[g];
        localparam int P    = 50 + HOLD;

        logic [NC*FL-1:0] cf;
        logic [1:0]       rw;
        logic             sh, st, oe, mr, dat, fd;
        logic [NC-1:0]    flt;

        assign cf = cf_all[NC*FL-1:0];

        rgb_matrix_shift_driver #(
            .NUM_CARS(NC), .FLOORS(FL), .CLK_DIV(CD), .HOLD_TICKS(HOLD),
            .BRIGHT(BR), .ROW_W(2), .ROW_SEL(3)
        ) dut (
            .clk(clk), .rst(rst), .car_floor(cf), .row(rw),
            .SH_CP(sh), .ST_CP(st), .OE(oe), .MR(mr), .data(dat),
            .frame_done(fd), .fault(flt)
        );

        assign act_a[g] = {sh, st, dat, oe, mr, rw, fd, 3'(flt)};

        // Position in frame of the tick on posedge number nn (1-based since reset).
        function automatic int qpos(int nn);
            return (nn / CD - 1) % P;
        endfunction

        function automatic logic [23:0] build(logic [7:0] c);
            logic [23:0] f;
            logic [7:0]  fld;
            f = '0;
            for (int k = 0; k < NC; k++) begin
                fld = (c >> (k * FL)) & 8'((1 << FL) - 1);
                if ($countones(fld) == 1) f = f | (24'(fld) << (8 * (2 - k % 3) + k * FL));
            end
            return f;
        endfunction

        function automatic logic [NC-1:0] badm(logic [7:0] c);
            logic [NC-1:0] b;
            logic [7:0]    fld;
            b = '0;
            for (int k = 0; k < NC; k++) begin
                fld = (c >> (k * FL)) & 8'((1 << FL) - 1);
                b[k] = ($countones(fld) != 1);
            end
            return b;
        endfunction

        int            mn;
        int            mq;
        logic          mstarted;
        logic [23:0]   mframe;
        logic [NC-1:0] mfault;
        logic          mfd;
        logic [10:0]   expv, carev;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mn       <= 0;
                mq       <= 0;
                mstarted <= 1'b0;
                mframe   <= '0;
                mfault   <= '0;
                mfd      <= 1'b0;
            end else begin
                mn  <= mn + 1;
                mfd <= 1'b0;
                if ((mn + 1) % CD == 0) begin
                    mstarted <= 1'b1;
                    mq       <= qpos(mn + 1);
                    if (qpos(mn + 1) == 0) begin
                        mframe <= build(cf_all);
                        mfault <= mfault | badm(cf_all);
                    end
                    if (qpos(mn + 1) == 49) mfd <= 1'b1;
                end
            end
        end

        always_comb begin
            expv      = 11'b000_1_0_00_0_000;
            carev     = '1;
            expv[6]   = (mn >= 1);
            expv[5:4] = (mn >= 1) ? 2'd3 : 2'd0;
            if (mstarted) begin
                if (mq <= 47) begin
                    expv[10] = mq[0];
                    expv[8]  = mframe[5'(23 - mq / 2)];
                end else if (mq == 48) begin
                    expv[9]  = 1'b1;
                    carev[8] = 1'b0;
                end else if (mq <= 48 + HOLD) begin
                    expv[7] = (((mq - 49) % 16) < BR) ? 1'b0 : 1'b1;
                end
            end
            expv[3]   = mfd;
            expv[2:0] = 3'(mfault);
        end

        assign exp_a[g]  = expv;
        assign care_a[g] = carev;
    end

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          prev_fd    [NCFG];
    int          oe_cnt     [NCFG];
    int          rise_cnt   [NCFG];
    int          first_rise [NCFG];
    int          last_rise  [NCFG];
    logic        have_prev  [NCFG];
    logic        sh_prev    [NCFG];
    logic [23:0] word0, last_word0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // One clock: compare every configuration at the falling edge, then
    // return shortly after the next rising edge for the caller to drive.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("outputs cfg%0d cyc%0d", g, cyc),
                32'(act_a[g] & care_a[g]), 32'(exp_a[g] & care_a[g]));
            if (rst) begin
                have_prev[g] = 1'b0;
                oe_cnt[g]    = 0;
                rise_cnt[g]  = 0;
                sh_prev[g]   = 1'b0;
            end else begin
                if (act_a[g][3]) begin
                    chk($sformatf("rises cfg%0d cyc%0d", g, cyc), 32'(rise_cnt[g]), 32'd24);
                    if (rise_cnt[g] == 24)
                        chk($sformatf("rise span cfg%0d", g), 32'(last_rise[g] - first_rise[g]), 32'(EXP_SPAN[g]));
                    if (have_prev[g]) begin
                        chk($sformatf("frame period cfg%0d", g), 32'(cyc - prev_fd[g]), 32'(EXP_PERIOD[g]));
                        chk($sformatf("oe low clks cfg%0d", g), 32'(oe_cnt[g]), 32'(EXP_OE[g]));
                    end
                    if (g == 0) last_word0 = word0;
                    have_prev[g] = 1'b1;
                    prev_fd[g]   = cyc;
                    oe_cnt[g]    = 0;
                    rise_cnt[g]  = 0;
                end
                if (!act_a[g][7]) oe_cnt[g]++;
                if (act_a[g][10] && !sh_prev[g]) begin
                    if (rise_cnt[g] == 0) first_rise[g] = cyc;
                    last_rise[g] = cyc;
                    rise_cnt[g]++;
                    if (g == 0) word0 = {word0[22:0], act_a[g][8]};
                end
                sh_prev[g] = act_a[g][10];
            end
        end
        @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] onehot4();
        return 4'(1 << $urandom_range(3, 0));
    endfunction

    function automatic logic [3:0] rnd4();
        if ($urandom_range(15, 0) == 0) return 4'($urandom);
        return onehot4();
    endfunction

    initial begin
        logic found;
        word0      = '0;
        last_word0 = '0;
        for (int g = 0; g < NCFG; g++) begin
            have_prev[g] = 1'b0; sh_prev[g] = 1'b0; oe_cnt[g] = 0; rise_cnt[g] = 0;
            prev_fd[g] = 0; first_rise[g] = 0; last_rise[g] = 0;
        end
        rst    = 1'b1;
        cf_all = 8'b0010_0001;
        repeat (3) step();
        rst = 1'b0;

        // Nominal frame: car0 floor 0 on R, car1 floor 1 on G.
        repeat (150) step();
        chk("nominal frame word", 32'(last_word0), 32'h0001_2000);

        // Inputs toggle every clock; only the LOAD snapshot may matter.
        repeat (700) begin
            cf_all = {onehot4(), onehot4()};
            step();
        end

        // Car 1 two-hot, then fixed: fault must stay set.
        cf_all = 8'b0110_0001;
        repeat (250) step();
        cf_all = 8'b0010_0001;
        repeat (700) step();
        for (int g = 0; g < 3; g++)
            chk($sformatf("sticky fault cfg%0d", g), 32'(act_a[g][2:0]), 32'b010);

        // Asynchronous reset in the middle of shifting.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (act_a[0][10]) found = 1'b1;
            else step();
        end
        chk("reached shift before reset", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("async reset values cfg%0d", g), 32'(act_a[g]), 32'(11'b000_1_0_00_0_000));
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("MR low until first clk", 32'(act_a[0][6]), 32'd0);
        step();
        chk("MR and row after release", 32'(act_a[0][6:4]), 32'b111);

        // Random inputs including occasional non-one-hot fields.
        repeat (1200) begin
            cf_all = {rnd4(), rnd4()};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
